// File: rtl/oddr_clock_gen_programmable.sv
// oddr_clock_gen_programmable
//   Programmable forwarded-clock pattern generator for an ODDR output cell.
//   Each clk_i cycle carries two half-slots (bit0 -> ODDR D1, bit1 -> D2).
//   A period is 2N slots (N clk_i cycles): slots 0..N-1 high, N..2N-1 low,
//   so any integer division of clk_i (odd ratios included) can be forwarded.
//   Ratio changes and enable gating only take effect at period boundaries,
//   so a truncated high or low phase is never emitted.
//
// Ports
//   clk_i              single clock
//   reset_i            asynchronous, active-high reset
//   enable_i           1 = clock runs; 0 = stop low after the current period
//   cfg_v_i            new half-period value valid
//   cfg_half_period_i  new N (half-slots per phase), 0 is rejected
//   cfg_ready_o        1 = no change pending, a new cfg can be accepted
//   cfg_err_o          registered one-cycle pulse for a rejected N==0 cfg
//   clk_pattern_o      {D2, D1} pattern for the ODDR
//   period_start_o     high with the pattern that holds the rising edge
//   half_period_o      currently active N
module oddr_clock_gen_programmable #(
  parameter int half_period_width_p = 7,
  parameter int reset_half_period_p = 1
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic                           enable_i,
  input  logic                           cfg_v_i,
  input  logic [half_period_width_p-1:0] cfg_half_period_i,
  output logic                           cfg_ready_o,
  output logic                           cfg_err_o,
  output logic [1:0]                     clk_pattern_o,
  output logic                           period_start_o,
  output logic [half_period_width_p-1:0] half_period_o
);

  // One extra bit so 2N and the slot counter never overflow at N = 2^w-1.
  localparam int CW = half_period_width_p + 1;
  localparam logic [half_period_width_p-1:0] N_RST =
    reset_half_period_p[half_period_width_p-1:0];

  logic [CW-1:0]                  cnt_r;      // even slot index of bit0
  logic [half_period_width_p-1:0] n_r;        // active half period
  logic [half_period_width_p-1:0] n_pend_r;   // accepted, not yet applied
  logic                           pend_r;
  logic                           run_r;
  logic [1:0]                     pat_r;
  logic                           ps_r;
  logic                           err_r;

  logic [CW-1:0] n_ext, two_n, cnt_p1, cnt_p2;
  logic          wrap, boundary, cfg_zero, cfg_take, cfg_bad;

  always_comb begin
    n_ext    = {1'b0, n_r};
    two_n    = {n_r, 1'b0};
    cnt_p1   = cnt_r + CW'(1);
    cnt_p2   = cnt_r + CW'(2);
    wrap     = (cnt_p2 == two_n);
    // While stopped the counter sits at 0, so every stopped cycle is a
    // boundary: pending cfgs and re-enables are picked up right away.
    boundary = run_r ? wrap : (cnt_r == '0);
    cfg_zero = (cfg_half_period_i == '0);
    cfg_take = cfg_v_i & ~pend_r & ~cfg_zero;
    cfg_bad  = cfg_v_i & ~pend_r &  cfg_zero;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_r    <= '0;
      n_r      <= N_RST;
      n_pend_r <= '0;
      pend_r   <= 1'b0;
      run_r    <= 1'b0;
      pat_r    <= 2'b00;
      ps_r     <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      if (run_r) begin
        pat_r <= {(cnt_p1 < n_ext), (cnt_r < n_ext)};
        ps_r  <= (cnt_r == '0);
        cnt_r <= wrap ? '0 : cnt_p2;
      end else begin
        pat_r <= 2'b00;
        ps_r  <= 1'b0;
        cnt_r <= '0;
      end

      // Boundary uses the pending flag as it stood before this cycle, so a
      // cfg accepted in the boundary cycle waits for the next boundary.
      if (boundary) begin
        run_r <= enable_i;
        if (pend_r) begin
          n_r    <= n_pend_r;
          pend_r <= 1'b0;
        end
      end

      // Only possible when pend_r is clear, so never collides with the
      // boundary clear above.
      if (cfg_take) begin
        n_pend_r <= cfg_half_period_i;
        pend_r   <= 1'b1;
      end

      err_r <= cfg_bad;
    end
  end

  assign cfg_ready_o    = ~pend_r;
  assign cfg_err_o      = err_r;
  assign clk_pattern_o  = pat_r;
  assign period_start_o = ps_r;
  assign half_period_o  = n_r;

endmodule

// File: tb/tb_oddr_clock_gen_programmable.sv
module tb_oddr_clock_gen_programmable;

  logic       clk, reset, en, cfg_v;
  logic [6:0] cfg_n;
  logic       rdy, err, ps;
  logic [1:0] pat;
  logic [6:0] hp;

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;

  typedef struct {
    int         cyc;
    logic [1:0] pat;
    logic       ps;
    logic [6:0] hp;
    logic       rdy;
    logic       err;
  } exp_t;

  exp_t q[$];

  oddr_clock_gen_programmable #(
    .half_period_width_p(7),
    .reset_half_period_p(1)
  ) dut (
    .clk_i            (clk),
    .reset_i          (reset),
    .enable_i         (en),
    .cfg_v_i          (cfg_v),
    .cfg_half_period_i(cfg_n),
    .cfg_ready_o      (rdy),
    .cfg_err_o        (err),
    .clk_pattern_o    (pat),
    .period_start_o   (ps),
    .half_period_o    (hp)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- expectation helpers ----------------
  task automatic push(input int c, input logic [1:0] p, input logic s, input int h);
    exp_t e;
    e.cyc = c; e.pat = p; e.ps = s; e.hp = h[6:0]; e.rdy = 1'b1; e.err = 1'b0;
    q.push_back(e);
  endtask

  // count cycles of a repeating N-cycle period starting at cycle 'start':
  // cycle i of the period carries slots 2i (bit0) and 2i+1 (bit1); high if < N.
  task automatic push_period(input int start, input int n, input int h, input int count);
    logic [1:0] p;
    int i;
    for (int k = 0; k < count; k++) begin
      i    = k % n;
      p[0] = (2*i < n);
      p[1] = (2*i + 1 < n);
      push(start + k, p, (i == 0), h);
    end
  endtask

  task automatic set_rdy_lo(input int from, input int to);
    foreach (q[j]) if (q[j].cyc >= from && q[j].cyc <= to) q[j].rdy = 1'b0;
  endtask

  task automatic set_hp(input int c, input int h);
    foreach (q[j]) if (q[j].cyc == c) q[j].hp = h[6:0];
  endtask

  task automatic set_err(input int c);
    foreach (q[j]) if (q[j].cyc == c) q[j].err = 1'b1;
  endtask

  task automatic at_neg(input int k);
    while (cyc < k) @(negedge clk);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc < cyc) begin
      n_tests++;
      n_fail++;
      $display("FAIL missed_cyc%0d: expectation never checked (now cyc %0d)", q[0].cyc, cyc);
      void'(q.pop_front());
    end
    if (q.size() > 0 && q[0].cyc == cyc) begin
      n_tests++;
      if ({pat, ps, hp, rdy, err} !== {q[0].pat, q[0].ps, q[0].hp, q[0].rdy, q[0].err}) begin
        n_fail++;
        $display("FAIL cyc%0d: got pat=%b ps=%b hp=%0d rdy=%b err=%b, want pat=%b ps=%b hp=%0d rdy=%b err=%b",
                 cyc, pat, ps, hp, rdy, err,
                 q[0].pat, q[0].ps, q[0].hp, q[0].rdy, q[0].err);
      end
      void'(q.pop_front());
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1; en = 1'b1; cfg_v = 1'b0; cfg_n = '0;

    // Reset values, then N=1 clock starting two cycles after release.
    push(1, 2'b00, 1'b0, 1);
    push(2, 2'b00, 1'b0, 1);
    push(3, 2'b00, 1'b0, 1);
    push_period(4, 1, 1, 8);
    at_neg(2); reset = 1'b0;

    // N=5: accepted at a boundary, applied at the next one.
    at_neg(11);
    push_period(12, 1, 1, 2);
    set_rdy_lo(12, 12);
    set_hp(13, 5);
    push_period(14, 5, 5, 10);
    cfg_v = 1'b1; cfg_n = 7'd5;
    at_neg(12); cfg_v = 1'b0;

    // N=2 issued at cycle 2 of an N=5 period; N=3 while pending is ignored.
    at_neg(23);
    push_period(24, 5, 5, 5);
    set_rdy_lo(26, 27);
    set_hp(28, 2);
    push_period(29, 2, 2, 8);
    at_neg(25); cfg_v = 1'b1; cfg_n = 7'd2;
    at_neg(26); cfg_n = 7'd3;
    at_neg(27); cfg_v = 1'b0;

    // N=50, disable mid-period, stopped hold, re-enable; N=0 error; N=127.
    at_neg(36);
    push_period(37, 2, 2, 2);
    set_rdy_lo(37, 37);
    set_hp(38, 50);
    push_period(39, 50, 50, 50);
    for (int c = 89; c <= 96; c++) push(c, 2'b00, 1'b0, 50);
    push_period(97, 50, 50, 50);
    set_err(101);
    set_rdy_lo(121, 145);
    set_hp(146, 127);
    cfg_v = 1'b1; cfg_n = 7'd50;
    at_neg(37); cfg_v = 1'b0;
    at_neg(50); en = 1'b0;
    at_neg(95); en = 1'b1;
    at_neg(100); cfg_v = 1'b1; cfg_n = 7'd0;
    at_neg(101); cfg_v = 1'b0;
    at_neg(120); cfg_v = 1'b1; cfg_n = 7'd127;
    push_period(147, 127, 127, 127);
    at_neg(121); cfg_v = 1'b0;

    // Async reset mid-period with N=9 pending: pending value is discarded.
    at_neg(270);
    push_period(274, 127, 127, 10);
    set_rdy_lo(280, 283);
    for (int c = 284; c <= 286; c++) push(c, 2'b00, 1'b0, 1);
    push(287, 2'b00, 1'b0, 1);
    push_period(288, 1, 1, 8);
    at_neg(279); cfg_v = 1'b1; cfg_n = 7'd9;
    at_neg(280); cfg_v = 1'b0;
    at_neg(283);
    @(posedge clk);
    #1 reset = 1'b1;
    at_neg(286); reset = 1'b0;

    at_neg(300);
    if (q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
